// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Types shared by the caches, the RAM model and the memory-side arbiter.
//   word_t      : 32-bit memory word / address
//   ramstate_t  : status reported by the single-port RAM
//   arb_state_t : arbiter FSM state, exported so benches can probe by name
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    DSERVE,
    ISERVE,
    DDONE,
    IDONE
  } arb_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts cycles spent in a serve state and flags expiry on the cycle in which
// the count reaches TIMEOUT-1, so the arbiter can force a completion on the
// TIMEOUT-th serve cycle. The count saturates there. TIMEOUT == 0 disables it.
//   CLK       in  clock, rising edge
//   nRST      in  asynchronous active-low reset
//   i_clear   in  restart the count (asserted on entry to a serve state)
//   i_enable  in  a serve cycle is in progress
//   o_expired out serve cycle budget used up (combinational)
// -----------------------------------------------------------------------------
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits; keep at least one bit.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (TIMEOUT != 0) && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_enable && (r_count == LIMIT);

endmodule : mem_watchdog

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Memory-side responder for the icache/dcache pair. Arbitrates instruction and
// data requests onto one single-port RAM, data side first (a MEM-stage miss
// stalls the whole pipeline). Completion is signalled by a one-cycle low pulse
// on iwait/dwait with the registered load word. A RAM ERROR or a watchdog
// expiry completes the access with ERR_WORD and sets the sticky memerr flag.
//   CLK, nRST                 clock / asynchronous active-low reset
//   iREN, iaddr               icache read request and word address
//   iwait, iload              icache handshake (low one cycle) and read data
//   dREN, dWEN, daddr, dstore dcache read/write request, address, write data
//   dwait, dload              dcache handshake (low one cycle) and read data
//   ramREN, ramWEN            RAM enables (combinational from state + request)
//   ramaddr, ramstore         RAM address and write data
//   ramload, ramstate         RAM read data and status
//   memerr                    sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter word_t       ERR_WORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  arb_state_t r_state;
  arb_state_t w_next;
  word_t      r_iload;
  word_t      r_dload;
  logic       r_memerr;

  logic  w_dload_we;
  logic  w_iload_we;
  logic  w_set_err;
  word_t w_load_val;
  logic  w_serving;
  logic  w_enter_serve;
  logic  w_expired;

  assign w_serving     = (r_state == DSERVE) || (r_state == ISERVE);
  assign w_enter_serve = (r_state == IDLE) && ((w_next == DSERVE) || (w_next == ISERVE));

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_clear   (w_enter_serve),
    .i_enable  (w_serving),
    .o_expired (w_expired)
  );

  // State register plus the registered load words and error flag.
  // NOTE: every register here, including the load data, has a reset value:
  // the caches may sample iload/dload right after reset and must see zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_iload  <= '0;
      r_dload  <= '0;
      r_memerr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_dload_we) r_dload <= w_load_val;
      if (w_iload_we) r_iload <= w_load_val;
      if (w_set_err)  r_memerr <= 1'b1;
    end
  end

  // Next-state and completion decode. A dropped request aborts before any
  // completion is considered; ACCESS wins over a coincident watchdog expiry.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_dload_we = 1'b0;
    w_iload_we = 1'b0;
    w_set_err  = 1'b0;
    w_load_val = ramload;
    unique case (r_state)
      IDLE: begin
        if (dREN || dWEN)  w_next = DSERVE;
        else if (iREN)     w_next = ISERVE;
      end
      DSERVE: begin
        if (!(dREN || dWEN)) begin
          w_next = IDLE;
        end else if (ramstate == ACCESS) begin
          w_next     = DDONE;
          w_dload_we = !dWEN;
        end else if ((ramstate == ERROR) || w_expired) begin
          w_next     = DDONE;
          w_dload_we = 1'b1;
          w_set_err  = 1'b1;
          w_load_val = ERR_WORD;
        end
      end
      ISERVE: begin
        if (!iREN) begin
          w_next = IDLE;
        end else if (ramstate == ACCESS) begin
          w_next     = IDONE;
          w_iload_we = 1'b1;
        end else if ((ramstate == ERROR) || w_expired) begin
          w_next     = IDONE;
          w_iload_we = 1'b1;
          w_set_err  = 1'b1;
          w_load_val = ERR_WORD;
        end
      end
      DDONE:   w_next = IDLE;
      IDONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RAM drive and handshakes. Enables follow the live request so an abort
  // releases the RAM in the same cycle the cache drops it.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (r_state)
      DSERVE: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
      end
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      DDONE:   dwait = 1'b0;
      IDONE:   iwait = 1'b0;
      default: ;
    endcase
  end

  assign iload  = r_iload;
  assign dload  = r_dload;
  assign memerr = r_memerr;

endmodule : cache_mem_arbiter

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed bench. u_dut runs with TIMEOUT=8; u_dut0 (TIMEOUT=0) shares nRST,
// the address and the RAM status but has its own dcache read request, so it
// can be held in DSERVE while u_dut times out.
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN, dREN0;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      zero = 1'b0;

  logic  iwait, dwait, ramREN, ramWEN, memerr;
  word_t iload, dload, ramaddr, ramstore;
  logic  iwait0, dwait0, ramREN0, ramWEN0, memerr0;
  word_t iload0, dload0, ramaddr0, ramstore0;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.TIMEOUT(8), .ERR_WORD(32'hBAD1BAD1)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  cache_mem_arbiter #(.TIMEOUT(0), .ERR_WORD(32'hBAD1BAD1)) u_dut0 (
    .CLK(CLK), .nRST(nRST),
    .iREN(zero), .iaddr(iaddr), .iwait(iwait0), .iload(iload0),
    .dREN(dREN0), .dWEN(zero), .daddr(daddr), .dstore(dstore),
    .dwait(dwait0), .dload(dload0),
    .ramREN(ramREN0), .ramWEN(ramWEN0), .ramaddr(ramaddr0), .ramstore(ramstore0),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr0)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input arb_state_t obs, input arb_state_t exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%s expected=%s", tag, obs.name(), exp.name());
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; dREN0 = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;
    #1;
    // ---- reset state ----
    chks("rst_state", u_dut.r_state, IDLE);
    chkb("rst_iwait", iwait, 1'b1);
    chkb("rst_dwait", dwait, 1'b1);
    chk ("rst_iload", iload, 32'h0);
    chk ("rst_dload", dload, 32'h0);
    chkb("rst_ramREN", ramREN, 1'b0);
    chkb("rst_ramWEN", ramWEN, 1'b0);
    chk ("rst_ramaddr", ramaddr, 32'h0);
    chk ("rst_ramstore", ramstore, 32'h0);
    chkb("rst_memerr", memerr, 1'b0);

    // ---- 1: dcache read, 3 BUSY then ACCESS ----
    cyc(); dREN = 1'b1; daddr = 32'h100; ramstate = FREE; #1;
    chks("t1_idle", u_dut.r_state, IDLE);
    chkb("t1_idle_ren", ramREN, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      ramstate = (k == 3) ? ACCESS : BUSY;
      ramload  = (k == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      chks("t1_serve_state", u_dut.r_state, DSERVE);
      chkb("t1_serve_ren", ramREN, 1'b1);
      chk ("t1_serve_addr", ramaddr, 32'h100);
      chkb("t1_serve_dwait", dwait, 1'b1);
      chkb("t1_serve_iwait", iwait, 1'b1);
    end
    cyc(); dREN = 1'b0; ramstate = FREE; #1;
    chks("t1_done_state", u_dut.r_state, DDONE);
    chkb("t1_done_dwait", dwait, 1'b0);
    chkb("t1_done_ren", ramREN, 1'b0);
    chk ("t1_done_dload", dload, 32'hDEADBEEF);
    chkb("t1_done_iwait", iwait, 1'b1);
    cyc(); #1;
    chks("t1_after_state", u_dut.r_state, IDLE);
    chkb("t1_after_dwait", dwait, 1'b1);
    chk ("t1_after_dload", dload, 32'hDEADBEEF);

    // ---- 2: simultaneous dWEN and iREN, data wins ----
    cyc(); iREN = 1'b1; iaddr = 32'h0; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678; #1;
    chks("t2_idle", u_dut.r_state, IDLE);
    cyc(); ramstate = ACCESS; ramload = 32'h55555555; #1;
    chks("t2_dserve", u_dut.r_state, DSERVE);
    chkb("t2_wen", ramWEN, 1'b1);
    chkb("t2_ren", ramREN, 1'b0);
    chk ("t2_store", ramstore, 32'h12345678);
    chk ("t2_waddr", ramaddr, 32'h40);
    chkb("t2_iwait_hold", iwait, 1'b1);
    cyc(); dWEN = 1'b0; ramstate = FREE; #1;
    chks("t2_ddone", u_dut.r_state, DDONE);
    chkb("t2_dwait", dwait, 1'b0);
    chkb("t2_iwait_done", iwait, 1'b1);
    chk ("t2_dload_kept", dload, 32'hDEADBEEF);
    chkb("t2_wen_off", ramWEN, 1'b0);
    cyc(); #1;
    chks("t2_bubble", u_dut.r_state, IDLE);
    chkb("t2_bubble_ren", ramREN, 1'b0);
    cyc(); ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chks("t2_iserve", u_dut.r_state, ISERVE);
    chkb("t2_iren", ramREN, 1'b1);
    chk ("t2_iaddr", ramaddr, 32'h0);
    chkb("t2_iwen", ramWEN, 1'b0);
    cyc(); iREN = 1'b0; ramstate = FREE; #1;
    chks("t2_idone", u_dut.r_state, IDONE);
    chkb("t2_iwait", iwait, 1'b0);
    chkb("t2_dwait_idone", dwait, 1'b1);
    chk ("t2_iload", iload, 32'hCAFEF00D);
    cyc(); #1;
    chkb("t2_iwait_after", iwait, 1'b1);

    // ---- 3: RAM ERROR on icache read, memerr sticky ----
    cyc(); iREN = 1'b1; iaddr = 32'h80; #1;
    cyc(); ramstate = ERROR; #1;
    chks("t3_iserve", u_dut.r_state, ISERVE);
    chkb("t3_memerr_pre", memerr, 1'b0);
    cyc(); iREN = 1'b0; ramstate = FREE; #1;
    chks("t3_idone", u_dut.r_state, IDONE);
    chkb("t3_iwait", iwait, 1'b0);
    chk ("t3_iload_err", iload, 32'hBAD1BAD1);
    chkb("t3_memerr", memerr, 1'b1);
    cyc(); dREN = 1'b1; daddr = 32'h10; #1;
    cyc(); ramstate = ACCESS; ramload = 32'h0A0B0C0D; #1;
    cyc(); dREN = 1'b0; ramstate = FREE; #1;
    chk ("t3_good_dload", dload, 32'h0A0B0C0D);
    chkb("t3_good_dwait", dwait, 1'b0);
    chkb("t3_memerr_sticky", memerr, 1'b1);
    cyc(); #1;
    chkb("t3_memerr_sticky2", memerr, 1'b1);

    // ---- 5: dcache request dropped mid-serve ----
    cyc(); dREN = 1'b1; daddr = 32'h200; ramstate = BUSY; #1;
    cyc(); #1;
    chks("t5_serve1", u_dut.r_state, DSERVE);
    chkb("t5_serve1_ren", ramREN, 1'b1);
    cyc(); #1;
    chks("t5_serve2", u_dut.r_state, DSERVE);
    cyc(); dREN = 1'b0; #1;
    chkb("t5_drop_ren", ramREN, 1'b0);
    chkb("t5_drop_dwait", dwait, 1'b1);
    cyc(); ramstate = FREE; #1;
    chks("t5_abort_state", u_dut.r_state, IDLE);
    chkb("t5_abort_dwait", dwait, 1'b1);
    chk ("t5_abort_dload", dload, 32'h0A0B0C0D);
    chkb("t5_abort_ren", ramREN, 1'b0);

    // ---- 6: asynchronous reset mid-ISERVE ----
    cyc(); iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY; #1;
    cyc(); #1;
    chks("t6_iserve", u_dut.r_state, ISERVE);
    chkb("t6_iserve_ren", ramREN, 1'b1);
    chk ("t6_iserve_addr", ramaddr, 32'h300);
    #1 nRST = 1'b0;
    #1;
    chks("t6_rst_state", u_dut.r_state, IDLE);
    chkb("t6_rst_ren", ramREN, 1'b0);
    chk ("t6_rst_addr", ramaddr, 32'h0);
    chkb("t6_rst_iwait", iwait, 1'b1);
    chk ("t6_rst_iload", iload, 32'h0);
    chk ("t6_rst_dload", dload, 32'h0);
    chkb("t6_rst_memerr", memerr, 1'b0);
    cyc(); #1;
    chks("t6_held", u_dut.r_state, IDLE);
    nRST = 1'b1;
    cyc(); ramstate = ACCESS; ramload = 32'h600DCAFE; #1;
    chks("t6_reserve", u_dut.r_state, ISERVE);
    cyc(); iREN = 1'b0; ramstate = FREE; #1;
    chkb("t6_iwait", iwait, 1'b0);
    chk ("t6_iload", iload, 32'h600DCAFE);
    chkb("t6_memerr", memerr, 1'b0);

    // ---- 4: watchdog, TIMEOUT=8 vs TIMEOUT=0 ----
    cyc(); dREN = 1'b1; dREN0 = 1'b1; daddr = 32'h500; ramstate = BUSY; #1;
    for (int k = 1; k <= 8; k++) begin
      cyc(); #1;
      chks("t4_serve", u_dut.r_state, DSERVE);
      chkb("t4_serve_dwait", dwait, 1'b1);
    end
    cyc(); dREN = 1'b0; #1;
    chks("t4_done_state", u_dut.r_state, DDONE);
    chkb("t4_done_dwait", dwait, 1'b0);
    chk ("t4_done_dload", dload, 32'hBAD1BAD1);
    chkb("t4_done_memerr", memerr, 1'b1);
    for (int k = 0; k < 30; k++) begin
      cyc(); #1;
      chks("t4_nowd_state", u_dut0.r_state, DSERVE);
      chkb("t4_nowd_dwait", dwait0, 1'b1);
    end
    chkb("t4_nowd_memerr", memerr0, 1'b0);
    chks("t4_main_idle", u_dut.r_state, IDLE);
    cyc(); dREN0 = 1'b0; ramstate = FREE; #1;
    cyc(); #1;
    chks("t4_nowd_abort", u_dut0.r_state, IDLE);
    chk ("t4_nowd_dload", dload0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule : tb_cache_mem_arbiter
